// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared CAN receive types, field lengths and CRC-15 step
package can_pkg;

  typedef enum logic [3:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_ID_A,
    ST_SRR_RTR,
    ST_IDE,
    ST_ID_B,
    ST_RTR_EXT,
    ST_R1,
    ST_R0,
    ST_DLC,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL
  } can_state_e;

  localparam logic [14:0] CAN_CRC_POLY = 15'h4599;
  localparam int ID_A_LEN    = 11;
  localparam int ID_B_LEN    = 18;
  localparam int DLC_LEN     = 4;
  localparam int CRC_LEN     = 15;
  localparam int STUFF_LIMIT = 5;

  // Data bytes on the wire: remote frames carry none, DLC above 8 means 8.
  function automatic logic [3:0] byte_count(input logic rtr, input logic [3:0] dlc);
    if (rtr) return 4'd0;
    return (dlc > 4'd8) ? 4'd8 : dlc;
  endfunction

  // One serial step of the CAN CRC-15 shift register.
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[14];
    return {crc[13:0], 1'b0} ^ (fb ? CAN_CRC_POLY : 15'h0);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// rtl/can_crc15.sv - serial CAN CRC-15 accumulator shared by receive and transmit
module can_crc15
  import can_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic        bit_in_i,
  output logic [14:0] crc_o
);

  logic [14:0] crc_q, crc_d;

  // Clear restarts from zero and may absorb the current bit in the same cycle.
  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = en_i ? crc15_step(15'h0, bit_in_i) : 15'h0;
    end else if (en_i) begin
      crc_d = crc15_step(crc_q, bit_in_i);
    end
  end

  // CRC register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) crc_q <= 15'h0;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/can_frame_decoder.sv
// rtl/can_frame_decoder.sv - CAN receive decoder with de-stuffing, CRC-15 check and error pulses
module can_frame_decoder
  import can_pkg::*;
#(
  parameter int MAX_DATA_BYTES = 8,
  parameter int IDLE_BITS      = 11
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        sample_i,
  input  logic                        can_data_i,
  output logic                        frame_valid_o,
  output logic [28:0]                 id_o,
  output logic                        ext_frame_o,
  output logic                        rtr_o,
  output logic [3:0]                  dlc_o,
  output logic [8*MAX_DATA_BYTES-1:0] data_o,
  output logic                        crc_ok_o,
  output logic                        stuff_err_o,
  output logic                        form_err_o,
  output logic                        busy_o
);

  localparam int RCW = $clog2(IDLE_BITS + 1);

  can_state_e                     state_q, state_d;
  logic [RCW-1:0]                 rec_cnt_q, rec_cnt_d;
  logic [4:0]                     bit_cnt_q, bit_cnt_d;
  logic [2:0]                     byte_idx_q, byte_idx_d;
  logic                           last_bit_q, last_bit_d;
  logic [2:0]                     run_len_q, run_len_d;
  logic [10:0]                    id_a_q, id_a_d;
  logic [17:0]                    id_b_q, id_b_d;
  logic                           srr_rtr_q, srr_rtr_d;
  logic                           ext_q, ext_d;
  logic                           rtr_q, rtr_d;
  logic [3:0]                     dlc_q, dlc_d;
  logic [MAX_DATA_BYTES-1:0][7:0] data_q, data_d;
  logic [14:0]                    crc_rx_q, crc_rx_d;

  logic                           frame_valid_q, frame_valid_d;
  logic                           stuff_err_q, stuff_err_d;
  logic                           form_err_q, form_err_d;
  logic                           busy_q, busy_d;
  logic                           crc_ok_q, crc_ok_d;
  logic                           ext_out_q, ext_out_d;
  logic                           rtr_out_q, rtr_out_d;
  logic [28:0]                    id_out_q, id_out_d;
  logic [3:0]                     dlc_out_q, dlc_out_d;
  logic [MAX_DATA_BYTES-1:0][7:0] data_out_q, data_out_d;

  logic        crc_clear, crc_en, crc_bit;
  logic [14:0] crc_calc;
  logic        in_stuff_region, bit_en, stuff_violation;
  logic [3:0]  nbytes;

  can_crc15 u_crc (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (crc_clear),
    .en_i    (crc_en),
    .bit_in_i(crc_bit),
    .crc_o   (crc_calc)
  );

  // De-stuffing front end, then the field-walking FSM and output capture.
  always_comb begin
    state_d       = state_q;
    rec_cnt_d     = rec_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    byte_idx_d    = byte_idx_q;
    last_bit_d    = last_bit_q;
    run_len_d     = run_len_q;
    id_a_d        = id_a_q;
    id_b_d        = id_b_q;
    srr_rtr_d     = srr_rtr_q;
    ext_d         = ext_q;
    rtr_d         = rtr_q;
    dlc_d         = dlc_q;
    data_d        = data_q;
    crc_rx_d      = crc_rx_q;
    busy_d        = busy_q;
    crc_ok_d      = crc_ok_q;
    ext_out_d     = ext_out_q;
    rtr_out_d     = rtr_out_q;
    id_out_d      = id_out_q;
    dlc_out_d     = dlc_out_q;
    data_out_d    = data_out_q;
    frame_valid_d = 1'b0;
    stuff_err_d   = 1'b0;
    form_err_d    = 1'b0;
    crc_clear     = 1'b0;
    crc_en        = 1'b0;
    crc_bit       = can_data_i;
    bit_en        = 1'b0;
    stuff_violation = 1'b0;
    nbytes        = byte_count(rtr_q, dlc_q);

    // The delimiter state is outside this set, so it is never de-stuffed.
    in_stuff_region = (state_q inside {ST_ID_A, ST_SRR_RTR, ST_IDE, ST_ID_B, ST_RTR_EXT,
                                       ST_R1, ST_R0, ST_DLC, ST_DATA, ST_CRC});
    if (sample_i && in_stuff_region) begin
      if (run_len_q == 3'(STUFF_LIMIT)) begin
        if (can_data_i == last_bit_q) begin
          stuff_violation = 1'b1;
        end else begin
          last_bit_d = can_data_i;
          run_len_d  = 3'd1;
        end
      end else begin
        bit_en = 1'b1;
        if (can_data_i == last_bit_q) begin
          run_len_d = run_len_q + 3'd1;
        end else begin
          last_bit_d = can_data_i;
          run_len_d  = 3'd1;
        end
      end
    end

    case (state_q)
      ST_WAIT_IDLE: if (sample_i) begin
        if (!can_data_i) begin
          rec_cnt_d = '0;
        end else if (rec_cnt_q == RCW'(IDLE_BITS - 1)) begin
          rec_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          rec_cnt_d = rec_cnt_q + RCW'(1);
        end
      end
      ST_IDLE: if (sample_i && !can_data_i) begin
        state_d    = ST_ID_A;
        busy_d     = 1'b1;
        crc_clear  = 1'b1;
        crc_en     = 1'b1;
        bit_cnt_d  = '0;
        byte_idx_d = '0;
        last_bit_d = 1'b0;
        run_len_d  = 3'd1;
        data_d     = '0;
      end
      ST_ID_A: if (bit_en) begin
        crc_en = 1'b1;
        id_a_d = {id_a_q[9:0], can_data_i};
        if (bit_cnt_q == 5'(ID_A_LEN - 1)) begin
          bit_cnt_d = '0;
          state_d   = ST_SRR_RTR;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      ST_SRR_RTR: if (bit_en) begin
        crc_en    = 1'b1;
        srr_rtr_d = can_data_i;
        state_d   = ST_IDE;
      end
      ST_IDE: if (bit_en) begin
        crc_en = 1'b1;
        ext_d  = can_data_i;
        if (can_data_i) begin
          state_d = ST_ID_B;
        end else begin
          rtr_d   = srr_rtr_q;
          state_d = ST_R0;
        end
      end
      ST_ID_B: if (bit_en) begin
        crc_en = 1'b1;
        id_b_d = {id_b_q[16:0], can_data_i};
        if (bit_cnt_q == 5'(ID_B_LEN - 1)) begin
          bit_cnt_d = '0;
          state_d   = ST_RTR_EXT;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      ST_RTR_EXT: if (bit_en) begin
        crc_en  = 1'b1;
        rtr_d   = can_data_i;
        state_d = ST_R1;
      end
      ST_R1: if (bit_en) begin
        crc_en  = 1'b1;
        state_d = ST_R0;
      end
      ST_R0: if (bit_en) begin
        crc_en  = 1'b1;
        state_d = ST_DLC;
      end
      ST_DLC: if (bit_en) begin
        crc_en = 1'b1;
        dlc_d  = {dlc_q[2:0], can_data_i};
        if (bit_cnt_q == 5'(DLC_LEN - 1)) begin
          bit_cnt_d = '0;
          state_d   = (byte_count(rtr_q, dlc_d) == 4'd0) ? ST_CRC : ST_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      ST_DATA: if (bit_en) begin
        crc_en = 1'b1;
        for (int b = 0; b < MAX_DATA_BYTES; b++) begin
          if (3'(b) == byte_idx_q) data_d[b] = {data_q[b][6:0], can_data_i};
        end
        if (bit_cnt_q == 5'd7) begin
          bit_cnt_d = '0;
          if ({1'b0, byte_idx_q} == nbytes - 4'd1) state_d = ST_CRC;
          else byte_idx_d = byte_idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      ST_CRC: if (bit_en) begin
        crc_rx_d = {crc_rx_q[13:0], can_data_i};
        if (bit_cnt_q == 5'(CRC_LEN - 1)) begin
          bit_cnt_d = '0;
          state_d   = ST_CRC_DEL;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      ST_CRC_DEL: if (sample_i) begin
        busy_d    = 1'b0;
        rec_cnt_d = '0;
        state_d   = ST_WAIT_IDLE;
        if (can_data_i) begin
          frame_valid_d = 1'b1;
          crc_ok_d      = (crc_rx_q == crc_calc);
          id_out_d      = ext_q ? {id_a_q, id_b_q} : {18'd0, id_a_q};
          ext_out_d     = ext_q;
          rtr_out_d     = rtr_q;
          dlc_out_d     = dlc_q;
          data_out_d    = data_q;
        end else begin
          form_err_d = 1'b1;
        end
      end
      default: state_d = ST_WAIT_IDLE;
    endcase

    if (stuff_violation) begin
      stuff_err_d = 1'b1;
      busy_d      = 1'b0;
      rec_cnt_d   = '0;
      state_d     = ST_WAIT_IDLE;
    end
  end

  // State and datapath registers; pulses self-clear because their _d defaults to 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_WAIT_IDLE;
      rec_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      byte_idx_q    <= '0;
      last_bit_q    <= 1'b0;
      run_len_q     <= '0;
      id_a_q        <= '0;
      id_b_q        <= '0;
      srr_rtr_q     <= 1'b0;
      ext_q         <= 1'b0;
      rtr_q         <= 1'b0;
      dlc_q         <= '0;
      data_q        <= '0;
      crc_rx_q      <= '0;
      frame_valid_q <= 1'b0;
      stuff_err_q   <= 1'b0;
      form_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      crc_ok_q      <= 1'b0;
      ext_out_q     <= 1'b0;
      rtr_out_q     <= 1'b0;
      id_out_q      <= '0;
      dlc_out_q     <= '0;
      data_out_q    <= '0;
    end else begin
      state_q       <= state_d;
      rec_cnt_q     <= rec_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_idx_q    <= byte_idx_d;
      last_bit_q    <= last_bit_d;
      run_len_q     <= run_len_d;
      id_a_q        <= id_a_d;
      id_b_q        <= id_b_d;
      srr_rtr_q     <= srr_rtr_d;
      ext_q         <= ext_d;
      rtr_q         <= rtr_d;
      dlc_q         <= dlc_d;
      data_q        <= data_d;
      crc_rx_q      <= crc_rx_d;
      frame_valid_q <= frame_valid_d;
      stuff_err_q   <= stuff_err_d;
      form_err_q    <= form_err_d;
      busy_q        <= busy_d;
      crc_ok_q      <= crc_ok_d;
      ext_out_q     <= ext_out_d;
      rtr_out_q     <= rtr_out_d;
      id_out_q      <= id_out_d;
      dlc_out_q     <= dlc_out_d;
      data_out_q    <= data_out_d;
    end
  end

  assign frame_valid_o = frame_valid_q;
  assign id_o          = id_out_q;
  assign ext_frame_o   = ext_out_q;
  assign rtr_o         = rtr_out_q;
  assign dlc_o         = dlc_out_q;
  assign data_o        = data_out_q;
  assign crc_ok_o      = crc_ok_q;
  assign stuff_err_o   = stuff_err_q;
  assign form_err_o    = form_err_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_can_frame_decoder.sv
// tb/tb_can_frame_decoder.sv - self-checking bench for can_frame_decoder
module tb_can_frame_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample = 1'b0;
  logic        can_data = 1'b1;

  logic        fv, ext, rtr, crc_ok, se, fe, busy;
  logic [28:0] id;
  logic [3:0]  dlc;
  logic [63:0] data;

  logic        fv2, ext2, rtr2, crc_ok2, se2, fe2, busy2;
  logic [28:0] id2;
  logic [3:0]  dlc2;
  logic [15:0] data2;

  int errors = 0;
  int checks = 0;
  int fv_cnt = 0, fv2_cnt = 0, se_cnt = 0, fe_cnt = 0;
  bit busy_seen = 0;

  bit          raw_q[$];
  bit          tx_q[$];
  logic [15:0] gpoly = 16'hC599;

  can_frame_decoder #(.MAX_DATA_BYTES(8), .IDLE_BITS(11)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sample_i(sample), .can_data_i(can_data),
    .frame_valid_o(fv), .id_o(id), .ext_frame_o(ext), .rtr_o(rtr), .dlc_o(dlc),
    .data_o(data), .crc_ok_o(crc_ok), .stuff_err_o(se), .form_err_o(fe), .busy_o(busy)
  );

  can_frame_decoder #(.MAX_DATA_BYTES(2), .IDLE_BITS(11)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .sample_i(sample), .can_data_i(can_data),
    .frame_valid_o(fv2), .id_o(id2), .ext_frame_o(ext2), .rtr_o(rtr2), .dlc_o(dlc2),
    .data_o(data2), .crc_ok_o(crc_ok2), .stuff_err_o(se2), .form_err_o(fe2), .busy_o(busy2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fv)   fv_cnt++;
    if (fv2)  fv2_cnt++;
    if (se)   se_cnt++;
    if (fe)   fe_cnt++;
    if (busy) busy_seen = 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int n_bytes(input bit r, input logic [3:0] d);
    if (r) return 0;
    if (d > 4'd8) return 8;
    return int'(d);
  endfunction

  task automatic push_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) raw_q.push_back(v[i]);
  endtask

  task automatic build(input bit e, input logic [28:0] idv, input bit r, input logic [3:0] d,
                       input logic [63:0] dat, input logic [14:0] flip);
    bit          m[$];
    logic [14:0] c;
    int          run;
    bit          last;
    raw_q.delete();
    tx_q.delete();
    raw_q.push_back(0);
    if (!e) begin
      push_bits(64'(idv[10:0]), 11);
      raw_q.push_back(r); raw_q.push_back(0); raw_q.push_back(0);
    end else begin
      push_bits(64'(idv[28:18]), 11);
      raw_q.push_back(1); raw_q.push_back(1);
      push_bits(64'(idv[17:0]), 18);
      raw_q.push_back(r); raw_q.push_back(0); raw_q.push_back(0);
    end
    push_bits(64'(d), 4);
    for (int b = 0; b < n_bytes(r, d); b++) push_bits(64'(dat[8*b +: 8]), 8);
    // CRC as the remainder of message * x^15 divided by the generator polynomial.
    m = raw_q;
    repeat (15) m.push_back(0);
    for (int i = 0; i < raw_q.size(); i++)
      if (m[i]) for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ gpoly[15-j];
    for (int k = 0; k < 15; k++) c[14-k] = m[raw_q.size() + k];
    c = c ^ flip;
    push_bits(64'(c), 15);
    run = 0;
    last = 0;
    for (int i = 0; i < raw_q.size(); i++) begin
      tx_q.push_back(raw_q[i]);
      if (run > 0 && raw_q[i] == last) run++;
      else run = 1;
      last = raw_q[i];
      if (run == 5 && i < raw_q.size() - 1) begin
        tx_q.push_back(!last);
        last = !last;
        run = 1;
      end
    end
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk);
    can_data = b;
    sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    can_data = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic run_frame(input int pre_idle, input bit delim, input bit exp_busy);
    for (int i = 0; i < pre_idle; i++) send_bit(1);
    foreach (tx_q[i]) begin
      send_bit(tx_q[i]);
      if (i == 0) check("busy_after_sof", 64'(busy), 64'(exp_busy));
    end
    send_bit(delim);
    check("busy_after_frame", 64'(busy), 64'd0);
    send_bit(0);
    repeat (10) send_bit(1);
  endtask

  task automatic check_frame(input string tag, input int fv0, input int fv20, input bit e,
                             input logic [28:0] idv, input bit r, input logic [3:0] d,
                             input logic [63:0] dat, input bit ok);
    logic [63:0] exp_data;
    exp_data = '0;
    for (int b = 0; b < n_bytes(r, d); b++) exp_data[8*b +: 8] = dat[8*b +: 8];
    check({tag, ".fv_pulses"}, 64'(fv_cnt - fv0), 64'd1);
    check({tag, ".fv2_pulses"}, 64'(fv2_cnt - fv20), 64'd1);
    check({tag, ".id"}, 64'(id), e ? 64'(idv) : 64'(idv[10:0]));
    check({tag, ".ext"}, 64'(ext), 64'(e));
    check({tag, ".rtr"}, 64'(rtr), 64'(r));
    check({tag, ".dlc"}, 64'(dlc), 64'(d));
    check({tag, ".data"}, data, exp_data);
    check({tag, ".crc_ok"}, 64'(crc_ok), 64'(ok));
    check({tag, ".data2"}, 64'(data2), 64'(exp_data[15:0]));
    check({tag, ".crc_ok2"}, 64'(crc_ok2), 64'(ok));
  endtask

  initial begin
    int          fv0, fv20, se0, fe0;
    bit          e, r;
    logic [28:0] idv;
    logic [3:0]  d;
    logic [63:0] dat;

    repeat (3) @(negedge clk);
    check("reset_outputs", {fv, ext, rtr, crc_ok, se, fe, busy, dlc, id}, 64'd0);
    check("reset_data", data, 64'd0);
    rst_n = 1'b1;

    // Standard data frame with two bytes.
    fv0 = fv_cnt; fv20 = fv2_cnt;
    build(0, 29'h551, 0, 4'd2, 64'h3CA5, 15'h0);
    run_frame(11, 1, 1);
    check_frame("std", fv0, fv20, 0, 29'h551, 0, 4'd2, 64'h3CA5, 1);

    // Extended remote frame.
    fv0 = fv_cnt; fv20 = fv2_cnt;
    build(1, 29'h15488320, 1, 4'd0, 64'h0, 15'h0);
    run_frame(11, 1, 1);
    check_frame("ext_rtr", fv0, fv20, 1, 29'h15488320, 1, 4'd0, 64'h0, 1);

    // Stuff violation: SOF plus six dominant bits without a stuff bit.
    fv0 = fv_cnt; se0 = se_cnt;
    repeat (11) send_bit(1);
    repeat (7) send_bit(0);
    check("stuff.err_pulses", 64'(se_cnt - se0), 64'd1);
    check("stuff.busy", 64'(busy), 64'd0);
    check("stuff.no_fv", 64'(fv_cnt - fv0), 64'd0);
    check("stuff.outputs_held", 64'(id), 64'h15488320);
    fv0 = fv_cnt; fv20 = fv2_cnt;
    build(0, 29'h551, 0, 4'd2, 64'h3CA5, 15'h0);
    run_frame(11, 1, 1);
    check_frame("after_stuff", fv0, fv20, 0, 29'h551, 0, 4'd2, 64'h3CA5, 1);

    // Corrupted CRC bit.
    fv0 = fv_cnt; fv20 = fv2_cnt;
    build(0, 29'h551, 0, 4'd2, 64'h3CA5, 15'h0100);
    run_frame(11, 1, 1);
    check_frame("crc_bad", fv0, fv20, 0, 29'h551, 0, 4'd2, 64'h3CA5, 0);

    // Dominant CRC delimiter.
    fv0 = fv_cnt; fe0 = fe_cnt;
    build(1, 29'h0ABCDEF, 0, 4'd1, 64'h77, 15'h0);
    run_frame(11, 0, 1);
    check("form.err_pulses", 64'(fe_cnt - fe0), 64'd1);
    check("form.no_fv", 64'(fv_cnt - fv0), 64'd0);
    check("form.held_crc_ok", 64'(crc_ok), 64'd0);

    // SOF after only five recessive bits is ignored.
    fv0 = fv_cnt;
    send_bit(0);
    busy_seen = 0;
    build(0, 29'h123, 0, 4'd1, 64'h5A, 15'h0);
    run_frame(5, 1, 0);
    check("idle_qual.busy_seen", 64'(busy_seen), 64'd0);
    check("idle_qual.no_fv", 64'(fv_cnt - fv0), 64'd0);

    // Reset in the middle of the data field.
    build(0, 29'h2F0, 0, 4'd8, 64'h0123456789ABCDEF, 15'h0);
    repeat (11) send_bit(1);
    for (int i = 0; i < 30; i++) send_bit(tx_q[i]);
    check("mid_reset.busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #2;
    check("mid_reset.outputs", {fv, ext, rtr, crc_ok, se, fe, busy, dlc, id}, 64'd0);
    check("mid_reset.data", data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fv0 = fv_cnt; busy_seen = 0;
    run_frame(5, 1, 0);
    check("mid_reset.unqualified_fv", 64'(fv_cnt - fv0), 64'd0);
    check("mid_reset.unqualified_busy", 64'(busy_seen), 64'd0);
    fv0 = fv_cnt; fv20 = fv2_cnt;
    run_frame(11, 1, 1);
    check_frame("post_reset_dlc8", fv0, fv20, 0, 29'h2F0, 0, 4'd8, 64'h0123456789ABCDEF, 1);

    // Randomized frames including DLC 9..15 and remote frames.
    for (int n = 0; n < 8; n++) begin
      e   = 1'($urandom_range(0, 1));
      r   = ($urandom_range(0, 3) == 0);
      idv = 29'($urandom);
      if (!e) idv = {18'd0, idv[10:0]};
      d   = 4'($urandom_range(0, 15));
      dat = {32'($urandom), 32'($urandom)};
      fv0 = fv_cnt; fv20 = fv2_cnt;
      build(e, idv, r, d, dat, 15'h0);
      run_frame(11 + $urandom_range(0, 3), 1, 1);
      check_frame($sformatf("rand%0d", n), fv0, fv20, e, idv, r, d, dat, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/can_frame_decoder.md
Name: can_frame_decoder

Overview:
- Next-generation CAN receive decoder, successor to the earlier ID-only decoder; works on the recovered bit stream from the bit-timing front end.
- Adds bit de-stuffing, DLC and data-field capture, CRC-15 check, bus-idle qualification and error reporting, with a parametrised data depth.
- Presents each complete frame (std/ext, data/remote) as a one-cycle result pulse to the acceptance/host logic.

Parameters:
- MAX_DATA_BYTES, 8: stored data bytes (1..8). Bytes beyond this are received and CRC'd but not stored.
- IDLE_BITS, 11: consecutive recessive bits required before an SOF is accepted.

Ports:
- clk, input, 1: single system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- sample, input, 1: one-cycle strobe; can_data is valid on this cycle.
- can_data, input, 1: bus bit; 0 = dominant.
- frame_valid, output, 1: one-cycle pulse when a frame completes.
- id, output, 29: std: id[10:0] with id[28:11]=0; ext: {ID_A, ID_B}.
- ext_frame, output, 1: IDE was recessive.
- rtr, output, 1: remote frame.
- dlc, output, 4: raw DLC field.
- data, output, 8*MAX_DATA_BYTES: byte 0 in data[7:0]; unused bytes are 0.
- crc_ok, output, 1: received CRC equals the computed CRC; valid with frame_valid.
- stuff_err, output, 1: one-cycle pulse on a stuff violation.
- form_err, output, 1: one-cycle pulse when the CRC delimiter is dominant.
- busy, output, 1: high from SOF acceptance until the frame ends or aborts.

Behaviour:
- Reset: all outputs 0; FSM enters WAIT_IDLE; recessive counter 0.
- State changes and output updates occur only on clk edges where sample=1, except that result and error pulses last exactly one clk cycle.
- Latency: frame_valid, stuff_err and form_err assert on the clk edge that registers the deciding bit. They are high in the cycle after that sample cycle.
- FSM states: WAIT_IDLE, IDLE, ID_A, SRR_RTR, IDE, ID_B, RTR_EXT, R1, R0, DLC, DATA, CRC, CRC_DEL.
- WAIT_IDLE: counts consecutive recessive samples and clears on dominant. At IDLE_BITS it goes to IDLE.
- IDLE: a dominant sample is SOF. Go to ID_A, set busy, clear the CRC and stuff counters, and feed SOF to the CRC.
- ID_A: 11 bits, MSB first. SRR_RTR: 1 bit, held. IDE: 0 means std, next state R0, and the held bit is rtr. IDE: 1 means ext, next state ID_B (18 bits), then RTR_EXT, then R1, then R0. The SRR value is ignored.
- R1 and R0: values ignored.
- DLC: 4 bits. Byte count = rtr ? 0 : min(dlc, 8).
- DATA: byte count × 8 bits, MSB first per byte. It is skipped when the count is 0.
- CRC: 15 bits compared against the running CRC. The CRC covers de-stuffed bits from SOF through the last data bit. Polynomial 15'h4599, init 0.
- CRC_DEL:
  - If recessive: pulse frame_valid, latch crc_ok, and go to WAIT_IDLE. The ACK, EOF and intermission then satisfy the idle count.
  - If dominant: pulse form_err with no frame_valid, then go to WAIT_IDLE.
- De-stuffing applies from SOF through the last CRC bit.
  - Track the last bit value and a run length.
  - After 5 equal bits, the next sample is a stuff bit. It is not fed to the FSM or CRC, and it resets the run length to 1 with the new value.
  - If the stuff bit equals the previous value: pulse stuff_err, drop busy, go to WAIT_IDLE, and leave outputs unchanged.
  - The CRC delimiter is never de-stuffed.
- Output latching: id, ext_frame, rtr, dlc and data update only together with frame_valid, and hold until the next valid frame.
- Data handling: data is zero-filled at SOF. Stored bytes are limited to MAX_DATA_BYTES.
- A dominant bit in WAIT_IDLE restarts the count; a mid-bus SOF without idle qualification is ignored.
- rst_n low mid-frame: immediate return to the reset state, with no pulse.
- Widths: the bit counter is 5 bits and the byte index is 3 bits. DLC values 9–15 are treated as 8.

Decomposition:
- Package can_pkg holds:
  - the FSM state encoding;
  - CAN_CRC_POLY = 15'h4599;
  - field lengths ID_A_LEN = 11, ID_B_LEN = 18, DLC_LEN = 4, CRC_LEN = 15;
  - STUFF_LIMIT = 5.
- Sub-module can_crc15 (clk, rst_n, clear, en, bit_in, crc[14:0]) is reused later by the transmitter.

Test Plan:
- Std data frame: IDLE_BITS recessive, then ID 0x551, DLC 2, data A5 3C, correct CRC, properly stuffed. Expect frame_valid=1 for 1 cycle, id=0x551, ext_frame=0, rtr=0, dlc=2, data[15:0]=0x3CA5, crc_ok=1.
- Ext remote frame: ID_A 0x552, SRR=1, IDE=1, ID_B 0x08320, RTR=1, DLC 0. Expect id=29'h15488320, ext_frame=1, rtr=1, data=0, crc_ok=1.
- Stuff violation: SOF followed by 6 dominant ID bits with no stuff bit. Expect stuff_err pulse, busy=0, no frame_valid. A following valid frame after 11 recessive bits decodes normally.
- CRC corruption: flip one CRC bit of the std frame. Expect frame_valid with crc_ok=0. A dominant CRC delimiter instead gives form_err and no frame_valid.
- Idle qualification: SOF after only 5 recessive bits is ignored (busy stays 0). rst_n pulsed mid-DATA gives all outputs 0 and requires 11 recessive bits before the next frame.
- MAX_DATA_BYTES=2 with DLC 8: data holds bytes 0–1 only, and crc_ok=1 (all 8 bytes included in the CRC).
